// File: rtl/fetch_decode.sv
// fetch_decode: non-pipelined RV32I fetch and decode front end feeding execute
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstb,
  output logic [31:0] i_addr,
  output logic        i_rd_req,
  input  logic        i_rd_ready,
  input  logic [31:0] i_rd_data,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  input  logic        ls_done,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic        op_lui,
  output logic        op_auipc,
  output logic        op_jal,
  output logic        op_jalr,
  output logic        op_branch,
  output logic        op_load,
  output logic        op_store,
  output logic        op_imm,
  output logic        op_reg,
  output logic [31:0] imm_signed,
  output logic [31:0] imm_unsigned,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [4:0]  dest,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] instret
);
  typedef enum logic [1:0] {ST_START, ST_FETCH, ST_EXEC, ST_WAIT_LS} state_t;
  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ex_pc_q;
  logic [31:0] inst_q;
  logic [31:0] instret_q;
  logic        req_q;
  logic [6:0]  opc;
  assign opc          = inst_q[6:0];
  assign op_lui       = opc == 7'b0110111;
  assign op_auipc     = opc == 7'b0010111;
  assign op_jal       = opc == 7'b1101111;
  assign op_jalr      = opc == 7'b1100111;
  assign op_branch    = opc == 7'b1100011;
  assign op_load      = opc == 7'b0000011;
  assign op_store     = opc == 7'b0100011;
  assign op_imm       = opc == 7'b0010011;
  assign op_reg       = opc == 7'b0110011;
  assign imm_unsigned = {20'h0, inst_q[31:20]};
  assign src1         = inst_q[19:15];
  assign src2         = inst_q[24:20];
  assign dest         = inst_q[11:7];
  assign funct3       = inst_q[14:12];
  assign funct7       = inst_q[31:25];
  assign i_addr       = pc_q;
  assign i_rd_req     = req_q;
  assign ex_valid     = state_q == ST_EXEC;
  assign ex_pc        = ex_pc_q;
  assign instret      = instret_q;
  // Immediate selected by instruction format; the held instruction word keeps it stable through WAIT_LS
  always_comb begin
    imm_signed = (op_lui | op_auipc) ? {inst_q[31:12], 12'h0} :
                 op_jal    ? {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0} :
                 op_branch ? {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0} :
                 op_store  ? {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]} :
                             {{20{inst_q[31]}}, inst_q[31:20]};
  end
  // Sequencer: request, capture instruction, present to execute, then advance pc or wait for load/store
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_START;
      pc_q      <= RESET_PC;
      ex_pc_q   <= 32'h0;
      inst_q    <= 32'h0;
      instret_q <= 32'h0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_START: begin
          req_q   <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_FETCH: if (req_q && i_rd_ready) begin
          inst_q  <= i_rd_data;
          ex_pc_q <= pc_q;
          req_q   <= 1'b0;
          state_q <= ST_EXEC;
        end
        ST_EXEC: if (op_load || op_store) begin
          state_q <= ST_WAIT_LS;
        end else begin
          pc_q      <= jmp ? (jmp_addr & 32'hFFFF_FFFC) : pc_q + 32'd4;
          instret_q <= instret_q + 32'd1;
          req_q     <= 1'b1;
          state_q   <= ST_FETCH;
        end
        default: if (ls_done) begin
          pc_q      <= pc_q + 32'd4;
          instret_q <= instret_q + 32'd1;
          req_q     <= 1'b1;
          state_q   <= ST_FETCH;
        end
      endcase
    end
  end
endmodule
